// File: rtl/mprj_chk_pkg.sv
// mprj_chk_pkg
// Shared definitions for the mprj checkpoint monitor:
//   - FSM state encodings (IDLE, WAIT, PASS, FAIL) as 2-bit constants
//   - width helpers for the step index, watchdog and stability counters
//   - default firmware signature constants
// Optional feature macro used by the monitor: MPRJ_CHK_FAIL_SIG_EN.
package mprj_chk_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [15:0] CHK_SIG_START = 16'hAB40;
  localparam logic [15:0] CHK_SIG_PASS  = 16'hAB51;

  // Step index must be able to hold NUM_STEPS itself (the post-pass value).
  function automatic int chk_idx_w(input int num_steps);
    return $clog2(num_steps) + 1;
  endfunction

  // Watchdog counter width; never narrower than one bit, even when disabled.
  function automatic int chk_wdog_w(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Stability counter must reach STABLE_CYCLES exactly.
  function automatic int chk_stab_w(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mprj_checkpoint_monitor_if.sv
// mprj_checkpoint_monitor_if
// Bundles the control, observation and status signals of the checkpoint
// monitor.
//   master modport (bench / firmware side):
//     out: start, clear, checkbits, exp_table [, fail_sig]
//     in : busy, step_idx, step_hit, pass, fail, timeout [, fail_step]
//   slave modport (monitor side): the same signals, opposite directions.
// Macro MPRJ_CHK_FAIL_SIG_EN adds fail_sig and fail_step.
interface mprj_checkpoint_monitor_if #(
  parameter int CHK_W     = 16,
  parameter int NUM_STEPS = 4
);
  import mprj_chk_pkg::*;

  localparam int IDX_W = chk_idx_w(NUM_STEPS);

  logic                       start;
  logic                       clear;
  logic [CHK_W-1:0]           checkbits;
  logic [NUM_STEPS*CHK_W-1:0] exp_table;
  logic                       busy;
  logic [IDX_W-1:0]           step_idx;
  logic                       step_hit;
  logic                       pass;
  logic                       fail;
  logic                       timeout;
`ifdef MPRJ_CHK_FAIL_SIG_EN
  logic [CHK_W-1:0]           fail_sig;
  logic [IDX_W-1:0]           fail_step;

  modport master (
    output start, clear, checkbits, exp_table, fail_sig,
    input  busy, step_idx, step_hit, pass, fail, timeout, fail_step
  );

  modport slave (
    input  start, clear, checkbits, exp_table, fail_sig,
    output busy, step_idx, step_hit, pass, fail, timeout, fail_step
  );
`else
  modport master (
    output start, clear, checkbits, exp_table,
    input  busy, step_idx, step_hit, pass, fail, timeout
  );

  modport slave (
    input  start, clear, checkbits, exp_table,
    output busy, step_idx, step_hit, pass, fail, timeout
  );
`endif

endinterface

// File: rtl/mprj_chk_stable.sv
// mprj_chk_stable
// Match-and-stability counter. Counts consecutive samples equal to
// 'expected'; any mismatch (including X/Z bits) zeroes the count.
// 'confirmed' is high once STABLE_CYCLES consecutive matches have been seen,
// so the owner acts on it one edge after the last required sample.
//   clock, resetb : sampling clock, async active-low reset
//   restart       : synchronous zeroing of the count
//   sample        : observed value
//   expected      : value to match
//   confirmed     : registered-count decode, high at STABLE_CYCLES
module mprj_chk_stable #(
  parameter int CHK_W         = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             restart,
  input  logic [CHK_W-1:0] sample,
  input  logic [CHK_W-1:0] expected,
  output logic             confirmed
);
  import mprj_chk_pkg::*;

  localparam int               STAB_W   = chk_stab_w(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

  logic [STAB_W-1:0] cnt;

  // An X/Z compare result falls into the else branch, i.e. a mismatch.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (sample == expected) begin
      if (cnt != STAB_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign confirmed = (cnt == STAB_MAX);

endmodule

// File: rtl/mprj_checkpoint_monitor.sv
// mprj_checkpoint_monitor
// Ordered checkpoint sequencer: watches checkbits and confirms NUM_STEPS
// expected signatures in order, each held for STABLE_CYCLES samples, with a
// per-step watchdog of TIMEOUT_CYCLES (0 disables it).
//   clock  : sampling clock
//   resetb : asynchronous active-low reset
//   bus    : slave side of mprj_checkpoint_monitor_if
//            in : start, clear, checkbits, exp_table [, fail_sig]
//            out: busy, step_idx, step_hit, pass, fail, timeout [, fail_step]
// Optional macro MPRJ_CHK_FAIL_SIG_EN: a stable fail_sig in WAIT forces FAIL
// without timeout and records the failing step in fail_step.
module mprj_checkpoint_monitor #(
  parameter int CHK_W          = 16,
  parameter int NUM_STEPS      = 4,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int STABLE_CYCLES  = 2
) (
  input logic                     clock,
  input logic                     resetb,
  mprj_checkpoint_monitor_if.slave bus
);
  import mprj_chk_pkg::*;

  localparam int                IDX_W     = chk_idx_w(NUM_STEPS);
  localparam int                WDOG_W    = chk_wdog_w(TIMEOUT_CYCLES);
  localparam bit                WDOG_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [WDOG_W-1:0] WDOG_LAST =
    WDOG_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [IDX_W-1:0]  LAST_STEP = IDX_W'(NUM_STEPS - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  step_idx;
  logic              step_hit_q;
  logic              pass_q;
  logic              fail_q;
  logic              timeout_q;
  logic [WDOG_W-1:0] wdog;

  logic [CHK_W-1:0]  exp_cur;
  logic              in_wait;
  logic              step_confirmed;
  logic              fail_confirmed;
  logic              wdog_expired;
  logic              step_restart;

  // Select the signature for the current step; index NUM_STEPS (after
  // pass) selects nothing and yields zero.
  always_comb begin
    exp_cur = '0;
    for (int k = 0; k < NUM_STEPS; k++) begin
      if (step_idx == IDX_W'(k)) begin
        exp_cur = bus.exp_table[k*CHK_W +: CHK_W];
      end
    end
  end

  assign in_wait = (state == ST_WAIT);

  // A confirmed hit restarts matching so the next step needs a fresh window.
  assign step_restart = !in_wait || bus.clear || step_confirmed;

  // Expires on the edge that would make the count reach TIMEOUT_CYCLES.
  assign wdog_expired = WDOG_EN && (wdog == WDOG_LAST);

  mprj_chk_stable #(
    .CHK_W         (CHK_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_step_stable (
    .clock     (clock),
    .resetb    (resetb),
    .restart   (step_restart),
    .sample    (bus.checkbits),
    .expected  (exp_cur),
    .confirmed (step_confirmed)
  );

`ifdef MPRJ_CHK_FAIL_SIG_EN
  logic             fail_restart;
  logic [IDX_W-1:0] fail_step_q;

  assign fail_restart = !in_wait || bus.clear;

  mprj_chk_stable #(
    .CHK_W         (CHK_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_fail_stable (
    .clock     (clock),
    .resetb    (resetb),
    .restart   (fail_restart),
    .sample    (bus.checkbits),
    .expected  (bus.fail_sig),
    .confirmed (fail_confirmed)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      fail_step_q <= '0;
    end else if (bus.clear) begin
      fail_step_q <= '0;
    end else if (in_wait && fail_confirmed) begin
      fail_step_q <= step_idx;
    end
  end

  assign bus.fail_step = fail_step_q;
`else
  assign fail_confirmed = 1'b0;
`endif

  // Priority inside WAIT: clear, fail signature, hit, watchdog expiry.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      step_idx   <= '0;
      step_hit_q <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      wdog       <= '0;
    end else if (bus.clear) begin
      state      <= ST_IDLE;
      step_idx   <= '0;
      step_hit_q <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      wdog       <= '0;
    end else begin
      step_hit_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state    <= ST_WAIT;
            step_idx <= '0;
            wdog     <= '0;
          end
        end
        ST_WAIT: begin
          if (fail_confirmed) begin
            state  <= ST_FAIL;
            fail_q <= 1'b1;
          end else if (step_confirmed) begin
            step_hit_q <= 1'b1;
            step_idx   <= step_idx + 1'b1;
            wdog       <= '0;
            if (step_idx == LAST_STEP) begin
              state  <= ST_PASS;
              pass_q <= 1'b1;
            end
          end else if (wdog_expired) begin
            state     <= ST_FAIL;
            fail_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else if (WDOG_EN) begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  assign bus.busy     = in_wait;
  assign bus.step_idx = step_idx;
  assign bus.step_hit = step_hit_q;
  assign bus.pass     = pass_q;
  assign bus.fail     = fail_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// tb_mprj_checkpoint_monitor
// Directed bench for mprj_checkpoint_monitor with NUM_STEPS=3,
// STABLE_CYCLES=2, TIMEOUT_CYCLES=100 and signatures {AB51,2233,AB40}.
// Inputs change on the falling edge; outputs are checked 1 ns after the
// rising edge. Macro MPRJ_CHK_FAIL_SIG_EN enables the fail_sig sequences.
module tb_mprj_checkpoint_monitor;
  import mprj_chk_pkg::*;

  logic clock;
  logic resetb;
  int   assertCount;
  int   failCount;

  mprj_checkpoint_monitor_if #(.CHK_W(16), .NUM_STEPS(3)) bus ();

  mprj_checkpoint_monitor #(
    .CHK_W          (16),
    .NUM_STEPS      (3),
    .TIMEOUT_CYCLES (100),
    .STABLE_CYCLES  (2)
  ) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] cb;
    logic        st;
    logic        cl;
    logic        busy;
    logic [2:0]  idx;
    logic        hit;
    logic        pass;
    logic        fail;
    logic        tmo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [15:0] cb, input logic st, input logic cl,
                              input logic b, input logic [2:0] i, input logic h,
                              input logic p, input logic f, input logic t);
    vec_t r;
    r.cb = cb; r.st = st; r.cl = cl;
    r.busy = b; r.idx = i; r.hit = h; r.pass = p; r.fail = f; r.tmo = t;
    return r;
  endfunction

  task automatic applyStimulus(input logic [15:0] cb, input logic st, input logic cl);
    @(negedge clock);
    bus.checkbits = cb;
    bus.start     = st;
    bus.clear     = cl;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic b, input logic [2:0] i,
                             input logic h, input logic p, input logic f, input logic t);
    logic [7:0] act;
    logic [7:0] expv;
    act  = {bus.busy, bus.step_idx, bus.step_hit, bus.pass, bus.fail, bus.timeout};
    expv = {b, i, h, p, f, t};
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: busy/idx/hit/pass/fail/tmo got %b/%0d/%b/%b/%b/%b expected %b/%0d/%b/%b/%b/%b",
               name, bus.busy, bus.step_idx, bus.step_hit, bus.pass, bus.fail, bus.timeout,
               b, i, h, p, f, t);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    assertCount   = 0;
    failCount     = 0;
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.checkbits = 16'h0000;
    bus.exp_table = {CHK_SIG_PASS, 16'h2233, CHK_SIG_START};
`ifdef MPRJ_CHK_FAIL_SIG_EN
    bus.fail_sig  = 16'hDEAD;
`endif
    resetb = 1'b1;
    #2 resetb = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clock) resetb = 1'b1;
    applyStimulus(16'h0000, 0, 0);
    checkOutput("idle_after_reset", 0, 0, 0, 0, 0, 0);

    // Full pass, PASS hold, clear, rerun with out-of-order, glitch and X.
    vecs.push_back(mk(16'h0000, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB40, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB40, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB40, 0, 0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(16'h2233, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(16'h2233, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(16'h2233, 0, 0, 1, 2, 1, 0, 0, 0));
    vecs.push_back(mk(16'hAB51, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB51, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB51, 0, 0, 0, 3, 1, 1, 0, 0));
    vecs.push_back(mk(16'h0000, 0, 0, 0, 3, 0, 1, 0, 0));
    vecs.push_back(mk(16'hAB40, 1, 0, 0, 3, 0, 1, 0, 0));
    vecs.push_back(mk(16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h0000, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h2233, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h2233, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h2233, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB51, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB51, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB51, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB40, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h0000, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB40, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB40, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16'h0000, 0, 0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(16'h2233, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(16'h22x3, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(16'h2233, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(16'h2233, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(16'h0000, 0, 0, 1, 2, 1, 0, 0, 0));
    vecs.push_back(mk(16'hAB51, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB51, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(16'hAB51, 0, 0, 0, 3, 1, 1, 0, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].cb, vecs[k].st, vecs[k].cl);
      checkOutput($sformatf("vec%0d", k), vecs[k].busy, vecs[k].idx, vecs[k].hit,
                  vecs[k].pass, vecs[k].fail, vecs[k].tmo);
    end

    // clear wins over a hit confirmed on the same edge
    applyStimulus(16'h0000, 0, 1);
    checkOutput("clear_pass", 0, 0, 0, 0, 0, 0);
    applyStimulus(16'h0000, 1, 0);
    applyStimulus(16'hAB40, 0, 0);
    applyStimulus(16'hAB40, 0, 0);
    applyStimulus(16'hAB40, 0, 1);
    checkOutput("clear_vs_hit", 0, 0, 0, 0, 0, 0);

    // watchdog expiry exactly 100 cycles after the step-0 hit
    applyStimulus(16'h0000, 1, 0);
    applyStimulus(16'hAB40, 0, 0);
    applyStimulus(16'hAB40, 0, 0);
    applyStimulus(16'hAB40, 0, 0);
    checkOutput("to_hit", 1, 1, 1, 0, 0, 0);
    repeat (99) applyStimulus(16'h0000, 0, 0);
    checkOutput("to_minus1", 1, 1, 0, 0, 0, 0);
    applyStimulus(16'h0000, 0, 0);
    checkOutput("to_expire", 0, 1, 0, 0, 1, 1);
    applyStimulus(16'hAB40, 1, 0);
    checkOutput("fail_hold", 0, 1, 0, 0, 1, 1);
    applyStimulus(16'h0000, 0, 1);
    checkOutput("clear_fail", 0, 0, 0, 0, 0, 0);

    // hit confirmed on the expiry edge wins, watchdog restarts from zero
    applyStimulus(16'h0000, 1, 0);
    repeat (97) applyStimulus(16'h0000, 0, 0);
    applyStimulus(16'hAB40, 0, 0);
    applyStimulus(16'hAB40, 0, 0);
    checkOutput("pre_expiry", 1, 0, 0, 0, 0, 0);
    applyStimulus(16'h0000, 0, 0);
    checkOutput("hit_on_expiry", 1, 1, 1, 0, 0, 0);
    repeat (99) applyStimulus(16'h0000, 0, 0);
    checkOutput("wdog_restart", 1, 1, 0, 0, 0, 0);
    applyStimulus(16'h0000, 0, 0);
    checkOutput("wdog_expire2", 0, 1, 0, 0, 1, 1);

    // asynchronous reset in the middle of a sequence
    applyStimulus(16'h0000, 0, 1);
    applyStimulus(16'h0000, 1, 0);
    applyStimulus(16'hAB40, 0, 0);
    applyStimulus(16'hAB40, 0, 0);
    applyStimulus(16'hAB40, 0, 0);
    checkOutput("pre_reset_hit", 1, 1, 1, 0, 0, 0);
    #1 resetb = 1'b0;
    #1;
    checkOutput("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clock) resetb = 1'b1;
    applyStimulus(16'hAB40, 0, 0);
    checkOutput("post_reset_idle", 0, 0, 0, 0, 0, 0);

`ifdef MPRJ_CHK_FAIL_SIG_EN
    // stable fail signature at step 1
    applyStimulus(16'h0000, 1, 0);
    applyStimulus(16'hAB40, 0, 0);
    applyStimulus(16'hAB40, 0, 0);
    applyStimulus(16'hAB40, 0, 0);
    applyStimulus(16'hDEAD, 0, 0);
    applyStimulus(16'hDEAD, 0, 0);
    checkOutput("failsig_pre", 1, 1, 0, 0, 0, 0);
    applyStimulus(16'hDEAD, 0, 0);
    checkOutput("failsig_fail", 0, 1, 0, 0, 1, 0);
    checkValue("fail_step1", 32'(bus.fail_step), 32'd1);

    // fail signature equal to the expected value: fail wins
    applyStimulus(16'h0000, 0, 1);
    bus.fail_sig = 16'hAB40;
    applyStimulus(16'h0000, 1, 0);
    applyStimulus(16'hAB40, 0, 0);
    applyStimulus(16'hAB40, 0, 0);
    applyStimulus(16'hAB40, 0, 0);
    checkOutput("failsig_vs_hit", 0, 0, 0, 0, 1, 0);
    checkValue("fail_step0", 32'(bus.fail_step), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mprj_checkpoint_monitor.md
Name: mprj_checkpoint_monitor

Overview:
- Parametrised checkpoint sequencer. It watches a CHK_W-bit slice of mprj_io (the "checkbits" the firmware writes) and confirms that NUM_STEPS expected signatures appear in order.
- Each step has its own watchdog, and each match needs a programmable stability window.
- Outputs are pass, fail and timeout flags plus a per-step hit pulse.
- It sits beside the caravel instance in user-project benches, replacing per-test hand-written wait/timeout blocks. It is written as synthesizable RTL so it can also be mapped into the user area as an on-chip self-check.

Parameters:
- CHK_W, 16: width of the observed checkbits and of each expected signature.
- NUM_STEPS, 4: number of ordered checkpoints (1..64).
- TIMEOUT_CYCLES, 2500000: per-step watchdog limit in clock cycles. 0 disables the watchdog.
- STABLE_CYCLES, 2: number of consecutive matching samples a hit requires (>=1).

Ports:
- clock, input, 1: sampling clock.
- resetb, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle pulse that arms the sequence from IDLE.
- clear, input, 1: synchronous return to IDLE from any state; clears all flags.
- checkbits, input, CHK_W: observed value; sampled each rising edge.
- exp_table, input, NUM_STEPS*CHK_W: expected signatures, step k at bits [k*CHK_W +: CHK_W]. Must be static while busy.
- busy, output, 1: high in WAIT.
- step_idx, output, $clog2(NUM_STEPS)+1: index of the step currently awaited; equals NUM_STEPS after pass.
- step_hit, output, 1: one-cycle pulse when a step is confirmed.
- pass, output, 1: sticky; all steps hit.
- fail, output, 1: sticky; timeout or fail signature.
- timeout, output, 1: sticky; qualifies fail as a watchdog expiry.

Behaviour:
- Reset: state=IDLE; step_idx=0; busy, step_hit, pass, fail and timeout all 0; stability and watchdog counters 0.
- States: IDLE, WAIT, PASS, FAIL.
- IDLE -> WAIT on start: step_idx=0, counters cleared.
- WAIT, matching:
  - sample == exp_table[step_idx] increments the stability counter.
  - Any mismatch zeroes it.
  - Any X/Z bit in the sample counts as a mismatch.
- WAIT, confirming a hit:
  - When the counter reaches STABLE_CYCLES, the next edge pulses step_hit, increments step_idx, and zeroes both counters.
  - Hit latency is STABLE_CYCLES+1 edges after the first matching sample.
- Identical consecutive signatures: after a hit the counter restarts, so step k+1 needs a further STABLE_CYCLES matching samples. A held value therefore satisfies the next step after STABLE_CYCLES more cycles.
- Out-of-order values, including earlier steps' signatures, are ignored; they are only mismatches.
- Last step hit: WAIT -> PASS, pass=1, busy=0, step_idx=NUM_STEPS.
- Watchdog:
  - Counts every cycle in WAIT and is zeroed on each hit.
  - Reaching TIMEOUT_CYCLES gives WAIT -> FAIL with fail=1 and timeout=1; step_idx freezes at the failing step.
- A hit and a watchdog expiry in the same cycle: the hit wins and the watchdog is zeroed.
- PASS and FAIL hold until clear or reset. start is ignored outside IDLE.
- clear has priority over every transition, including a same-cycle hit or timeout.
- resetb asserted mid-sequence returns asynchronously to reset values. Outputs are registered; no combinational path from checkbits to outputs.

Optional Feature:
- Macro: MPRJ_CHK_FAIL_SIG_EN.
- When defined:
  - Adds input fail_sig[CHK_W-1:0] and output fail_step[$clog2(NUM_STEPS)+1-1:0].
  - In WAIT, fail_sig held for STABLE_CYCLES samples gives -> FAIL with fail=1, timeout=0; fail_step captures step_idx.
  - fail_sig is checked before the step match; if fail_sig equals the current expected value, fail wins.
- When undefined: no extra ports; FAIL is reached only by timeout.

Decomposition:
- Package mprj_chk_pkg holds:
  - State enum {IDLE, WAIT, PASS, FAIL}.
  - Width-helper localparams: index width, watchdog width = $clog2(TIMEOUT_CYCLES+1) with minimum 1, stability width.
  - Default signature constants CHK_SIG_START=16'hAB40, CHK_SIG_PASS=16'hAB51.
- One sub-module, mprj_chk_stable: a match-and-stability counter that takes sample, expected and a restart input and produces a confirmed pulse. It is instantiated once for the step match and, under the macro, once for fail_sig.

Test Plan:
- Setup: NUM_STEPS=3, exp={AB51,2233,AB40}, STABLE=2. Drive AB40 x3, 2233 x3, AB51 x3 -> step_hit three times at the specified latency, step_idx 0->1->2->3, pass=1, fail=0.
- Out-of-order: drive 2233 then AB51 before AB40 -> no step_hit, step_idx=0, busy=1.
- Glitch: AB40 for 1 cycle then 0000, then AB40 for 2 cycles -> exactly one hit, after the second burst.
- Timeout: TIMEOUT_CYCLES=100, hit step 0, then hold 0000 -> fail=1, timeout=1 exactly 100 cycles after the hit, step_idx=1. Separately, a hit landing on the expiry cycle -> no fail.
- clear and reset: resetb low mid-step -> all outputs 0 immediately. clear in PASS -> IDLE, and a new start reruns the sequence successfully.
- With MPRJ_CHK_FAIL_SIG_EN and fail_sig=DEAD: drive DEAD for 2 cycles at step 1 -> fail=1, timeout=0, fail_step=1.
